// File: rtl/logic_reduce_acc_if.sv
// Handshake bundle for logic_reduce_acc: operand stream in, reduction result out.
// Optional out_parity signal is present when LOGIC_REDUCE_ACC_PARITY_EN is defined.
interface logic_reduce_acc_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [2:0]       op;
    logic [CNT_W-1:0] beats;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
`ifdef LOGIC_REDUCE_ACC_PARITY_EN
    logic             out_parity;

    modport master (
        output op, beats, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy, out_parity
    );

    modport slave (
        input  op, beats, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy, out_parity
    );
`else
    modport master (
        output op, beats, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy
    );

    modport slave (
        input  op, beats, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy
    );
`endif
endinterface

// File: rtl/logic_reduce_acc.sv
// logic_reduce_acc: folds a programmable number of WIDTH-bit operands with a
// bitwise AND/OR/XOR (optionally inverted once at the end) and presents the
// result on a valid/ready port. All outputs are registered.
// Optional feature macro: LOGIC_REDUCE_ACC_PARITY_EN adds out_parity (XOR of out_data).
module logic_reduce_acc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    logic_reduce_acc_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Base bitwise op used for every beat; inverting ops fold with their base op.
    function automatic logic [WIDTH-1:0] fold_op(input logic [2:0]       op_sel,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op_sel)
            3'b001, 3'b100: r = a | b;
            3'b010, 3'b101: r = a ^ b;
            default:        r = a & b;
        endcase
        return r;
    endfunction

    // True for NAND/NOR/XNOR: the folded value is inverted once on output.
    function automatic logic is_inverting(input logic [2:0] op_sel);
        logic r;
        case (op_sel)
            3'b011, 3'b100, 3'b101: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // Even-parity bit of a result word.
    function automatic logic parity_of(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    state_e           state_q,     state_d;
    logic [2:0]       op_q,        op_d;
    logic [CNT_W-1:0] beats_q,     beats_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_parity_q, out_parity_d;

    logic             accept_s;
    logic [CNT_W-1:0] beats_eff_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [WIDTH-1:0] result_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        beats_d     = beats_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        accept_s    = bus.in_valid && in_ready_q;
        beats_eff_s = (bus.beats == {CNT_W{1'b0}}) ? CNT_W'(1) : bus.beats;
        cnt_inc_s   = cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d    = bus.op;
                    beats_d = beats_eff_s;
                    acc_d   = bus.in_data;
                    cnt_d   = CNT_W'(1);
                    if (beats_eff_s == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (accept_s) begin
                    acc_d = fold_op(op_q, acc_q, bus.in_data);
                    cnt_d = cnt_inc_s;
                    // beats_q >= 2 here, so cnt reaches it before it can wrap.
                    if (cnt_inc_s == beats_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                    op_d    = 3'b000;
                    beats_d = {CNT_W{1'b0}};
                    acc_d   = {WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                op_d    = 3'b000;
                beats_d = {CNT_W{1'b0}};
                acc_d   = {WIDTH{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        // Outputs are a function of the next state so they come straight from flops.
        in_ready_d  = (state_d != ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        if (is_inverting(op_d)) begin
            result_s = ~acc_d;
        end else begin
            result_s = acc_d;
        end
        if (out_valid_d) begin
            out_data_d = result_s;
        end else begin
            out_data_d = {WIDTH{1'b0}};
        end
        out_parity_d = parity_of(out_data_d);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= 3'b000;
            beats_q      <= {CNT_W{1'b0}};
            acc_q        <= {WIDTH{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            out_data_q   <= {WIDTH{1'b0}};
            out_parity_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            beats_q      <= beats_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            out_data_q   <= out_data_d;
            out_parity_q <= out_parity_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_data  = out_data_q;

`ifdef LOGIC_REDUCE_ACC_PARITY_EN
    assign bus.out_parity = out_parity_q;
`else
    logic unused_parity_s;
    assign unused_parity_s = out_parity_q;
`endif

endmodule

// File: tb/tb_logic_reduce_acc.sv
// Bench for logic_reduce_acc: table of transactions plus hand-written corner
// sequences; expected results go through a queue and are compared on handshake.
module tb_logic_reduce_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic_reduce_acc_if #(.WIDTH(8), .CNT_W(4)) bus_if ();

    logic_reduce_acc #(.WIDTH(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [2:0]      op;
        logic [3:0]      beats;
        int              n;
        logic [0:3][7:0] d;
        int              gap;
        logic [7:0]      exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Scoreboard: compare each output handshake with the oldest expected result.
    always @(negedge clk) begin
        if (!rst && bus_if.out_valid && bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %0h expected none", bus_if.out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("out_data", {24'd0, bus_if.out_data}, {24'd0, e});
`ifdef LOGIC_REDUCE_ACC_PARITY_EN
                check("out_parity", {31'd0, bus_if.out_parity}, {31'd0, ^e});
`endif
            end
        end
    end

    // Offer one operand; returns at posedge+1 after it is accepted.
    task automatic send_beat(input logic [7:0] d);
        logic got;
        got = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = d;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = bus_if.in_ready;
            @(posedge clk);
            #1;
        end
        if (!got) timeout_fail("send_beat");
        bus_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) timeout_fail("drain");
    endtask

    task automatic run_txn(input logic [2:0] op, input logic [3:0] beats, input int n,
                           input logic [7:0] d [16], input int gap, input logic [7:0] exp);
        bus_if.op    = op;
        bus_if.beats = beats;
        exp_q.push_back(exp);
        for (int i = 0; i < n; i++) begin
            send_beat(d[i]);
            // Scramble op/beats after the first beat; the DUT must ignore them.
            bus_if.op    = 3'($urandom_range(0, 7));
            bus_if.beats = 4'($urandom_range(0, 15));
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check("busy_gap", {31'd0, bus_if.busy}, 32'd1);
                    check("valid_gap", {31'd0, bus_if.out_valid}, 32'd0);
                    @(posedge clk);
                    #1;
                end
            end
        end
        drain();
    endtask

    initial begin
        logic [7:0] buf16 [16];

        bus_if.op        = 3'b000;
        bus_if.beats     = 4'd0;
        bus_if.in_data   = 8'h00;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;

        vecs[0] = '{op: 3'b000, beats: 4'd3, n: 3, d: {8'hF0, 8'h3C, 8'hFF, 8'h00}, gap: 0, exp: 8'h30};
        vecs[1] = '{op: 3'b011, beats: 4'd3, n: 3, d: {8'hF0, 8'h3C, 8'hFF, 8'h00}, gap: 0, exp: 8'hCF};
        vecs[2] = '{op: 3'b010, beats: 4'd4, n: 4, d: {8'h01, 8'h02, 8'h04, 8'h08}, gap: 2, exp: 8'h0F};
        vecs[3] = '{op: 3'b001, beats: 4'd2, n: 2, d: {8'h11, 8'h22, 8'h00, 8'h00}, gap: 0, exp: 8'h33};
        vecs[4] = '{op: 3'b100, beats: 4'd2, n: 2, d: {8'h0C, 8'h30, 8'h00, 8'h00}, gap: 1, exp: 8'hC3};
        vecs[5] = '{op: 3'b101, beats: 4'd3, n: 3, d: {8'hFF, 8'h0F, 8'h33, 8'h00}, gap: 0, exp: 8'h3C};
        vecs[6] = '{op: 3'b110, beats: 4'd2, n: 2, d: {8'hF0, 8'h3C, 8'h00, 8'h00}, gap: 0, exp: 8'h30};
        vecs[7] = '{op: 3'b111, beats: 4'd0, n: 1, d: {8'h5A, 8'h00, 8'h00, 8'h00}, gap: 0, exp: 8'h5A};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("rst_out_data", {24'd0, bus_if.out_data}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single beat: result valid the cycle after acceptance, then back to IDLE.
        bus_if.op    = 3'b000;
        bus_if.beats = 4'd1;
        exp_q.push_back(8'hA5);
        send_beat(8'hA5);
        check("single_valid", {31'd0, bus_if.out_valid}, 32'd1);
        check("single_data", {24'd0, bus_if.out_data}, 32'h0000_00A5);
        check("single_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("single_idle_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("single_idle_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("single_idle_data", {24'd0, bus_if.out_data}, 32'd0);
        check("single_sb_empty", exp_q.size(), 32'd0);

        // Table-driven transactions.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 16; i++) buf16[i] = (i < 4) ? vecs[v].d[i] : 8'h00;
            run_txn(vecs[v].op, vecs[v].beats, vecs[v].n, buf16, vecs[v].gap, vecs[v].exp);
        end

        // Maximum length: 15 OR beats of single bits cover every bit.
        for (int i = 0; i < 16; i++) buf16[i] = 8'h01 << (i % 8);
        run_txn(3'b001, 4'd15, 15, buf16, 0, 8'hFF);

        // Backpressure: result held, in_ready low, new operand waits.
        bus_if.out_ready = 1'b0;
        bus_if.op        = 3'b001;
        bus_if.beats     = 4'd2;
        exp_q.push_back(8'h33);
        send_beat(8'h11);
        send_beat(8'h22);
        bus_if.op       = 3'b001;
        bus_if.beats    = 4'd1;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 8'h44;
        exp_q.push_back(8'h44);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, bus_if.out_valid}, 32'd1);
            check("bp_data", {24'd0, bus_if.out_data}, 32'h0000_0033);
            check("bp_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_released_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("bp_released_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("bp_sb_one_left", exp_q.size(), 32'd1);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        check("bp_next_valid", {31'd0, bus_if.out_valid}, 32'd1);
        check("bp_next_data", {24'd0, bus_if.out_data}, 32'h0000_0044);
        drain();

        // Mid-transaction reset discards the partial result.
        bus_if.op    = 3'b100;
        bus_if.beats = 4'd4;
        send_beat(8'h01);
        send_beat(8'h02);
        check("mid_busy", {31'd0, bus_if.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("mid_rst_ready", {31'd0, bus_if.in_ready}, 32'd1);
        for (int i = 0; i < 16; i++) buf16[i] = 8'h00;
        buf16[0] = 8'hFF;
        buf16[1] = 8'h0F;
        run_txn(3'b101, 4'd2, 2, buf16, 0, 8'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
